gomoku_keypad_entry: RTL

//  Scans the 4x4 matrix keypad, debounces it and sequences coordinate entry for the move in progress.
//  Key codes 8..15 select the column (x = code[2:0]); key codes 0..7 select the row (y = code[2:0]).
//  On an OK press with both coordinates held, the block issues one move request to the game core over a valid/ready handshake.
//  It sits between the keypad pins/btn_ok and the board/turn logic, and also drives cursor state for LED flicker.

---
 rtl/gomoku_keypad_entry.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/gomoku_keypad_entry.sv
// Keypad front end for the gomoku console: scans and debounces a 4x4 matrix,
// collects x/y coordinates and hands a finished move to the game core over valid/ready.
module gomoku_keypad_entry #(
   parameter int DEBOUNCE_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scan_tick,
   input  logic       enable,
   input  logic       clear,
   input  logic       btn_ok,
   input  logic [3:0] keyboard_row,
   output logic [3:0] keyboard_col,
   output logic       key_event,
   output logic [2:0] cursor_x,
   output logic [2:0] cursor_y,
   output logic       cursor_x_vld,
   output logic       cursor_y_vld,
   output logic       move_valid,
   output logic [2:0] move_x,
   output logic [2:0] move_y,
   input  logic       move_ready,
   output logic       entry_err
);

   typedef enum logic {
      COLLECT = 1'b0,
      REQUEST = 1'b1
   } entry_state_t;

   localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_FRAMES);

   // ---------------- column scan and frame accumulation ----------------
   logic [1:0] col_idx;
   logic [1:0] frame_hits;   // saturating key count for the frame so far (2 = multi)
   logic [3:0] frame_code;
   logic [3:0] row_hit;
   logic [2:0] col_hits;
   logic [1:0] col_row;
   logic [1:0] base_hits;
   logic [2:0] sum_hits;
   logic [1:0] new_hits;
   logic [3:0] new_code;
   logic       frame_done;

   assign keyboard_col = ~(4'b1000 >> col_idx);
   assign row_hit      = ~keyboard_row;
   assign col_hits     = {2'b00, row_hit[0]} + {2'b00, row_hit[1]}
                       + {2'b00, row_hit[2]} + {2'b00, row_hit[3]};
   assign frame_done   = scan_tick && (col_idx == 2'd3);

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      col_row = 2'd0;
      case (row_hit)
         4'b1000: col_row = 2'd0;
         4'b0100: col_row = 2'd1;
         4'b0010: col_row = 2'd2;
         4'b0001: col_row = 2'd3;
         default: col_row = 2'd0;
      endcase
   end

   always_comb begin
      base_hits = (col_idx == 2'd0) ? 2'd0 : frame_hits;
      sum_hits  = {1'b0, base_hits} + col_hits;
      new_hits  = (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
      new_code  = (base_hits == 2'd1) ? frame_code : {col_row, col_idx};
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_idx    <= 2'd0;
         frame_hits <= 2'd0;
         frame_code <= 4'd0;
      end else if (scan_tick) begin
         col_idx    <= col_idx + 2'd1;
         frame_hits <= new_hits;
         frame_code <= new_code;
      end
   end

   // ---------------- debounce ----------------
   logic       db_pressed, db_pressed_nx;
   logic [3:0] db_cnt, db_cnt_nx;
   logic [3:0] db_code, db_code_nx;
   logic       key_accept;

   always_comb begin
      db_pressed_nx = db_pressed;
      db_cnt_nx     = db_cnt;
      db_code_nx    = db_code;
      key_accept    = 1'b0;
      if (frame_done) begin
         if (!db_pressed) begin
            if (new_hits == 2'd1 && db_cnt != 4'd0 && new_code == db_code) begin
               db_cnt_nx = db_cnt + 4'd1;
            end else begin
               db_cnt_nx  = (new_hits == 2'd1) ? 4'd1 : 4'd0;
               db_code_nx = (new_hits == 2'd1) ? new_code : 4'd0;
            end
            if (db_cnt_nx == DB_TARGET) begin
               key_accept    = 1'b1;
               db_pressed_nx = 1'b1;
               db_cnt_nx     = 4'd0;
            end
         end else begin
            // in the pressed state the counter tracks consecutive empty frames
            db_cnt_nx = (new_hits == 2'd0) ? db_cnt + 4'd1 : 4'd0;
            if (db_cnt_nx == DB_TARGET) begin
               db_pressed_nx = 1'b0;
               db_cnt_nx     = 4'd0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_pressed <= 1'b0;
         db_cnt     <= 4'd0;
         db_code    <= 4'd0;
      end else begin
         db_pressed <= db_pressed_nx;
         db_cnt     <= db_cnt_nx;
         db_code    <= db_code_nx;
      end
   end

   // ---------------- entry FSM ----------------
   entry_state_t state, state_nx;
   logic       btn_ok_q;
   logic       ok_rise;
   logic       abort;
   logic       key_apply;
   logic [2:0] x_upd, y_upd;
   logic       xv_upd, yv_upd;
   logic       ok_fire;
   logic       ok_err;

   assign ok_rise   = btn_ok && !btn_ok_q;
   assign abort     = clear || !enable;
   assign key_apply = key_accept && enable;

   // an accepted key lands before OK is judged, so OK sees the refreshed flags
   always_comb begin
      x_upd  = cursor_x;
      y_upd  = cursor_y;
      xv_upd = cursor_x_vld;
      yv_upd = cursor_y_vld;
      if (key_apply && state == COLLECT) begin
         if (db_code_nx[3]) begin
            x_upd  = db_code_nx[2:0];
            xv_upd = 1'b1;
         end else begin
            y_upd  = db_code_nx[2:0];
            yv_upd = 1'b1;
         end
      end
   end

   assign ok_fire = (state == COLLECT) && ok_rise && !abort && xv_upd && yv_upd;
   assign ok_err  = (state == COLLECT) && ok_rise && !abort && !(xv_upd && yv_upd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         COLLECT: if (ok_fire) state_nx = REQUEST;
         REQUEST: if (abort || move_ready) state_nx = COLLECT;
         default: state_nx = COLLECT;
      endcase
   end

   always_comb begin
      move_valid = (state == REQUEST);
   end

   // ---------------- entry datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_ok_q     <= 1'b0;
         key_event    <= 1'b0;
         entry_err    <= 1'b0;
         cursor_x     <= 3'd0;
         cursor_y     <= 3'd0;
         cursor_x_vld <= 1'b0;
         cursor_y_vld <= 1'b0;
         move_x       <= 3'd0;
         move_y       <= 3'd0;
      end else begin
         btn_ok_q  <= btn_ok;
         key_event <= key_apply;
         entry_err <= ok_err;
         if (abort) begin
            cursor_x_vld <= 1'b0;
            cursor_y_vld <= 1'b0;
         end else if (state == REQUEST) begin
            if (move_ready) begin
               cursor_x_vld <= 1'b0;
               cursor_y_vld <= 1'b0;
            end
         end else begin
            cursor_x     <= x_upd;
            cursor_y     <= y_upd;
            cursor_x_vld <= xv_upd;
            cursor_y_vld <= yv_upd;
            if (ok_fire) begin
               move_x <= x_upd;
               move_y <= y_upd;
            end
         end
      end
   end

endmodule
